axi_rd_addr_router: RTL and testbench

//  Parametrised AXI read-path router for one master and NUM_SLAVES slaves, plus an internal default slave.

---
 rtl/axi_rd_router_pkg.sv | 23 ++
 rtl/axi_default_rd_slave.sv | 81 ++++++++
 rtl/axi_rd_addr_router.sv | 165 ++++++++++++++++
 tb/tb_axi_rd_addr_router.sv | 294 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/axi_rd_router_pkg.sv
// ----------------------------------------------------------------------------
// axi_rd_router_pkg
//   Shared definitions for the AXI read-address router. It holds the R
//   response codes, the default-slave FSM state type, and a helper that sizes
//   the target index. The index must cover every mapped slave plus the
//   internal default slave.
// ----------------------------------------------------------------------------
package axi_rd_router_pkg;

  localparam logic [1:0] RESP_OKAY   = 2'b00;
  localparam logic [1:0] RESP_DECERR = 2'b11;

  typedef enum logic {
    DEF_IDLE = 1'b0,
    DEF_RESP = 1'b1
  } def_state_e;

  // Width of an index able to name NUM_SLAVES mapped slaves plus the default.
  function automatic int tgt_idx_w(input int num_slaves);
    return (num_slaves < 1) ? 1 : $clog2(num_slaves + 1);
  endfunction

endpackage

// File: rtl/axi_default_rd_slave.sv
// ----------------------------------------------------------------------------
// axi_default_rd_slave
//   Completes reads to unmapped addresses with a DECERR burst of ARLEN+1
//   beats. It holds one burst at a time.
//   clk, rst    : clock, asynchronous active-high reset
//   ar_hs_i     : AR handshake addressed to this slave
//   arid_i      : ARID captured at the handshake
//   arlen_i     : ARLEN captured at the handshake
//   rready_i    : master RREADY, already gated by the router
//   idle_o      : high when a new burst can be accepted
//   rvalid_o, rid_o, rresp_o, rlast_o : R channel toward the router mux
// ----------------------------------------------------------------------------
module axi_default_rd_slave
  import axi_rd_router_pkg::*;
#(
  parameter int ID_W  = 8,
  parameter int LEN_W = 4
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            ar_hs_i,
  input  logic [ID_W-1:0] arid_i,
  input  logic [LEN_W-1:0] arlen_i,
  input  logic            rready_i,
  output logic            idle_o,
  output logic            rvalid_o,
  output logic [ID_W-1:0] rid_o,
  output logic [1:0]      rresp_o,
  output logic            rlast_o
);

  // Beat count is one wider than ARLEN so that ARLEN+1 never wraps.
  localparam int REM_W = LEN_W + 1;

  def_state_e       state_q, state_d;
  logic [REM_W-1:0] rem_q, rem_d;
  logic [ID_W-1:0]  id_q, id_d;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= DEF_IDLE;
      rem_q   <= '0;
      id_q    <= '0;
    end else begin
      // NOTE: registers take <= so every flop samples pre-edge values; '=' here would chain updates within one edge.
      state_q <= state_d;
      rem_q   <= rem_d;
      id_q    <= id_d;
    end
  end

  always_comb begin
    // NOTE: every comb output is defaulted first so no path leaves it unassigned, which would infer a latch.
    state_d = state_q;
    rem_d   = rem_q;
    id_d    = id_q;
    unique case (state_q)
      DEF_IDLE: begin
        if (ar_hs_i) begin
          id_d    = arid_i;
          rem_d   = REM_W'(arlen_i) + REM_W'(1);
          state_d = DEF_RESP;
        end
      end
      DEF_RESP: begin
        if (rready_i) begin
          rem_d = rem_q - REM_W'(1);
          if (rem_q == REM_W'(1)) state_d = DEF_IDLE;
        end
      end
      default: state_d = DEF_IDLE;
    endcase
  end

  assign idle_o   = (state_q == DEF_IDLE);
  assign rvalid_o = (state_q == DEF_RESP);
  assign rid_o    = id_q;
  assign rresp_o  = rvalid_o ? RESP_DECERR : RESP_OKAY;
  assign rlast_o  = rvalid_o && (rem_q == REM_W'(1));

endmodule

// File: rtl/axi_rd_addr_router.sv
// ----------------------------------------------------------------------------
// axi_rd_addr_router
//   Read-path router between one AXI master and NUM_SLAVES slaves. It also
//   contains an internal default slave that answers unmapped addresses with
//   DECERR. ARADDR[SEL_MSB:SEL_LSB] selects the slave. A new AR goes out only
//   when nothing is outstanding, or when it targets the same mapped slave as
//   the bursts already in flight. As a result, R beats always return in order
//   from a single source.
//   ACLK, ARESET              : clock, asynchronous active-high reset
//   ARADDR/ARID/ARLEN/ARVALID : master AR request (broadcast to slaves)
//   ARREADY                   : master AR ready
//   ARVALID_S / ARREADY_S     : per-slave AR handshake
//   RID_S/RDATA_S/RRESP_S     : packed slave R fields, slave k at slice k
//   RLAST_S/RVALID_S/RREADY_S : per-slave R control
//   RID/RDATA/RRESP/RLAST/RVALID/RREADY : master R channel
// ----------------------------------------------------------------------------
module axi_rd_addr_router
  import axi_rd_router_pkg::*;
#(
  parameter int NUM_SLAVES = 2,
  parameter int ADDR_W     = 32,
  parameter int ID_W       = 8,
  parameter int DATA_W     = 32,
  parameter int LEN_W      = 4,
  parameter int SEL_MSB    = 31,
  parameter int SEL_LSB    = 16,
  parameter int MAX_OUTST  = 4
) (
  input  logic                         ACLK,
  input  logic                         ARESET,
  input  logic [ADDR_W-1:0]            ARADDR,
  input  logic [ID_W-1:0]              ARID,
  input  logic [LEN_W-1:0]             ARLEN,
  input  logic                         ARVALID,
  output logic                         ARREADY,
  output logic [NUM_SLAVES-1:0]        ARVALID_S,
  input  logic [NUM_SLAVES-1:0]        ARREADY_S,
  input  logic [NUM_SLAVES*ID_W-1:0]   RID_S,
  input  logic [NUM_SLAVES*DATA_W-1:0] RDATA_S,
  input  logic [NUM_SLAVES*2-1:0]      RRESP_S,
  input  logic [NUM_SLAVES-1:0]        RLAST_S,
  input  logic [NUM_SLAVES-1:0]        RVALID_S,
  output logic [NUM_SLAVES-1:0]        RREADY_S,
  output logic [ID_W-1:0]              RID,
  output logic [DATA_W-1:0]            RDATA,
  output logic [1:0]                   RRESP,
  output logic                         RLAST,
  output logic                         RVALID,
  input  logic                         RREADY
);

  localparam int               TGT_W   = tgt_idx_w(NUM_SLAVES);
  localparam int               CNT_W   = $clog2(MAX_OUTST + 1);
  localparam int               SEL_W   = SEL_MSB - SEL_LSB + 1;
  localparam logic [TGT_W-1:0] DEF_IDX = TGT_W'(NUM_SLAVES);
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(MAX_OUTST);

  logic [SEL_W-1:0] sel;
  logic [TGT_W-1:0] target;
  logic [TGT_W-1:0] tgt_q, tgt_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             busy, allow, slave_rdy, ar_hs, r_done;
  logic             def_idle, def_rvalid, def_rlast, def_rready;
  logic [ID_W-1:0]  def_rid;
  logic [1:0]       def_rresp;
  logic             unused_addr_bits;

  // Only the select field matters for routing; the whole bus is reduced here
  // so the bits outside it are visibly consumed.
  assign unused_addr_bits = ^ARADDR;

  assign sel    = ARADDR[SEL_MSB:SEL_LSB];
  assign target = (sel < SEL_W'(NUM_SLAVES)) ? TGT_W'(sel) : DEF_IDX;
  assign busy   = (cnt_q != '0);
  // The default slave is excluded from the same-target clause.
  // It therefore only accepts when the router is completely empty.
  assign allow  = !busy || ((tgt_q == target) && (target != DEF_IDX) && (cnt_q < CNT_MAX));

  always_comb begin
    slave_rdy = 1'b0;
    ARVALID_S = '0;
    for (int k = 0; k < NUM_SLAVES; k++) begin
      if (target == TGT_W'(k)) begin
        slave_rdy    = ARREADY_S[k];
        ARVALID_S[k] = !ARESET && ARVALID && allow;
      end
    end
  end

  // ARESET masks ARREADY because allow is trivially true while cnt_q is held at 0.
  assign ARREADY = !ARESET && allow && ((target == DEF_IDX) ? def_idle : slave_rdy);
  assign ar_hs   = ARVALID && ARREADY;
  assign r_done  = RVALID && RREADY && RLAST;

  // R mux: only the slave that owns the outstanding bursts is visible.
  // Any other slave's beats wait with RREADY_S low.
  always_comb begin
    RVALID     = 1'b0;
    RID        = '0;
    RDATA      = '0;
    RRESP      = RESP_OKAY;
    RLAST      = 1'b0;
    RREADY_S   = '0;
    def_rready = 1'b0;
    if (busy && !ARESET) begin
      if (tgt_q == DEF_IDX) begin
        RVALID     = def_rvalid;
        RID        = def_rid;
        RRESP      = def_rresp;
        RLAST      = def_rlast;
        def_rready = RREADY;
      end else begin
        for (int k = 0; k < NUM_SLAVES; k++) begin
          if (tgt_q == TGT_W'(k)) begin
            RVALID      = RVALID_S[k];
            RID         = RID_S[k*ID_W +: ID_W];
            RDATA       = RDATA_S[k*DATA_W +: DATA_W];
            RRESP       = RRESP_S[k*2 +: 2];
            RLAST       = RLAST_S[k];
            RREADY_S[k] = RREADY;
          end
        end
      end
    end
  end

  always_comb begin
    tgt_d = tgt_q;
    cnt_d = cnt_q;
    if (ar_hs) tgt_d = target;
    unique case ({ar_hs, r_done})
      2'b10:   cnt_d = cnt_q + CNT_W'(1);
      2'b01:   cnt_d = cnt_q - CNT_W'(1);
      default: cnt_d = cnt_q;
    endcase
  end

  always_ff @(posedge ACLK or posedge ARESET) begin
    if (ARESET) begin
      tgt_q <= '0;
      cnt_q <= '0;
    end else begin
      tgt_q <= tgt_d;
      cnt_q <= cnt_d;
    end
  end

  axi_default_rd_slave #(
    .ID_W  (ID_W),
    .LEN_W (LEN_W)
  ) u_def_slave (
    .clk      (ACLK),
    .rst      (ARESET),
    .ar_hs_i  (ar_hs && (target == DEF_IDX)),
    .arid_i   (ARID),
    .arlen_i  (ARLEN),
    .rready_i (def_rready),
    .idle_o   (def_idle),
    .rvalid_o (def_rvalid),
    .rid_o    (def_rid),
    .rresp_o  (def_rresp),
    .rlast_o  (def_rlast)
  );

endmodule

// File: tb/tb_axi_rd_addr_router.sv
// ----------------------------------------------------------------------------
// tb_axi_rd_addr_router
//   Directed bench for axi_rd_addr_router with two mapped slaves, emulated by
//   the bench. Every R beat the master should see is queued when its source
//   is stimulated, and popped when the master channel is sampled.
// ----------------------------------------------------------------------------
module tb_axi_rd_addr_router;

  typedef struct packed {
    logic [7:0]  id;
    logic [31:0] data;
    logic [1:0]  resp;
    logic        last;
  } beat_t;

  logic        ACLK;
  logic        ARESET;
  logic [31:0] ARADDR;
  logic [7:0]  ARID;
  logic [3:0]  ARLEN;
  logic        ARVALID;
  logic        ARREADY;
  logic [1:0]  ARVALID_S;
  logic [1:0]  ARREADY_S;
  logic [15:0] RID_S;
  logic [63:0] RDATA_S;
  logic [3:0]  RRESP_S;
  logic [1:0]  RLAST_S;
  logic [1:0]  RVALID_S;
  logic [1:0]  RREADY_S;
  logic [7:0]  RID;
  logic [31:0] RDATA;
  logic [1:0]  RRESP;
  logic        RLAST;
  logic        RVALID;
  logic        RREADY;

  beat_t sb[$];
  int    n_assert = 0;
  int    n_fail   = 0;
  int    acc;
  bit    rdy;

  axi_rd_addr_router dut (
    .ACLK      (ACLK),
    .ARESET    (ARESET),
    .ARADDR    (ARADDR),
    .ARID      (ARID),
    .ARLEN     (ARLEN),
    .ARVALID   (ARVALID),
    .ARREADY   (ARREADY),
    .ARVALID_S (ARVALID_S),
    .ARREADY_S (ARREADY_S),
    .RID_S     (RID_S),
    .RDATA_S   (RDATA_S),
    .RRESP_S   (RRESP_S),
    .RLAST_S   (RLAST_S),
    .RVALID_S  (RVALID_S),
    .RREADY_S  (RREADY_S),
    .RID       (RID),
    .RDATA     (RDATA),
    .RRESP     (RRESP),
    .RLAST     (RLAST),
    .RVALID    (RVALID),
    .RREADY    (RREADY)
  );

  initial ACLK = 1'b0;
  always #5 ACLK = ~ACLK;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h, expected %0h", tag, obs, exp);
    end
  endtask

  // Advance to just after the next rising edge, where inputs are driven.
  task automatic tick();
    @(posedge ACLK);
    #1;
  endtask

  // Pop the next queued beat and compare it with the master R channel.
  task automatic expect_beat(input string tag);
    beat_t e;
    chk({tag, "_valid"}, 64'(RVALID), 64'(1));
    chk({tag, "_sb_level"}, 64'(sb.size() != 0), 64'(1));
    if (sb.size() != 0) begin
      e = sb.pop_front();
      chk({tag, "_beat"}, 64'({RID, RDATA, RRESP, RLAST}), 64'(e));
    end
  endtask

  // Emulated slave k presents one beat; it is handshaken at the next edge.
  task automatic slave_beat(input int k, input logic [7:0] id, input logic [31:0] data,
                            input logic last);
    RVALID_S[k]          = 1'b1;
    RID_S[k*8 +: 8]      = id;
    RDATA_S[k*32 +: 32]  = data;
    RRESP_S[k*2 +: 2]    = 2'b00;
    RLAST_S[k]           = last;
    sb.push_back(beat_t'{id: id, data: data, resp: 2'b00, last: last});
    #2;
    expect_beat("slave_r");
    chk("slave_rready_s", 64'(RREADY_S), 64'(RREADY) << k);
    tick();
    RVALID_S[k] = 1'b0;
    RLAST_S[k]  = 1'b0;
  endtask

  initial begin
    ARESET    = 1'b1;
    ARADDR    = 32'h0000_0010;
    ARID      = 8'h00;
    ARLEN     = 4'd0;
    ARVALID   = 1'b1;
    ARREADY_S = 2'b11;
    RID_S     = '0;
    RDATA_S   = '0;
    RRESP_S   = '0;
    RLAST_S   = '0;
    RVALID_S  = '0;
    RREADY    = 1'b1;

    // 1: reset holds the AR path and R path quiet even with ARVALID high.
    tick();
    tick();
    #2;
    chk("rst_arready", 64'(ARREADY), 64'(0));
    chk("rst_arvalid_s", 64'(ARVALID_S), 64'(0));
    chk("rst_rvalid", 64'(RVALID), 64'(0));
    ARESET  = 1'b0;
    ARVALID = 1'b0;
    tick();
    chk("rst_cnt", 64'(dut.cnt_q), 64'(0));

    // 2: slave0 read, then a slave1 read held until slave0 completes.
    ARVALID = 1'b1;
    ARADDR  = 32'h0000_0010;
    ARID    = 8'h01;
    #2;
    chk("t2_arvalid_s0", 64'(ARVALID_S), 64'(2'b01));
    chk("t2_arready0", 64'(ARREADY), 64'(1));
    tick();
    ARADDR = 32'h0001_0020;
    ARID   = 8'h02;
    #2;
    chk("t2_hold_arready", 64'(ARREADY), 64'(0));
    chk("t2_hold_arvalid_s", 64'(ARVALID_S), 64'(0));
    slave_beat(0, 8'h01, 32'h0000_00A0, 1'b1);
    #2;
    chk("t2_arvalid_s1", 64'(ARVALID_S), 64'(2'b10));
    chk("t2_arready1", 64'(ARREADY), 64'(1));
    tick();
    ARVALID = 1'b0;
    slave_beat(1, 8'h02, 32'h0000_00B0, 1'b1);
    chk("t2_cnt_end", 64'(dut.cnt_q), 64'(0));

    // 3: fill to MAX_OUTST, then complete and accept in the same cycle.
    ARVALID = 1'b1;
    ARLEN   = 4'd0;
    for (int i = 0; i < 4; i++) begin
      ARADDR = 32'h0000_0100 + 32'(i * 4);
      ARID   = 8'h10 + 8'(i);
      #2;
      chk("t3_arready", 64'(ARREADY), 64'(1));
      tick();
    end
    chk("t3_cnt_full", 64'(dut.cnt_q), 64'(4));
    ARADDR = 32'h0000_0200;
    ARID   = 8'h14;
    #2;
    chk("t3_full_arready", 64'(ARREADY), 64'(0));
    chk("t3_full_arvalid_s", 64'(ARVALID_S), 64'(0));
    slave_beat(0, 8'h10, 32'h0000_00C0, 1'b1);
    chk("t3_cnt_after_done", 64'(dut.cnt_q), 64'(3));
    #2;
    chk("t3_fifth_arready", 64'(ARREADY), 64'(1));
    slave_beat(0, 8'h11, 32'h0000_00C1, 1'b1);
    chk("t3_cnt_same_cycle", 64'(dut.cnt_q), 64'(3));
    ARADDR = 32'h0000_0204;
    ARID   = 8'h15;
    #2;
    chk("t3_sixth_arready", 64'(ARREADY), 64'(1));
    tick();
    ARVALID = 1'b0;
    chk("t3_cnt_refill", 64'(dut.cnt_q), 64'(4));
    for (int i = 0; i < 4; i++) begin
      slave_beat(0, 8'h12 + 8'(i), 32'h0000_00D0 + 32'(i), 1'b1);
    end
    chk("t3_cnt_drained", 64'(dut.cnt_q), 64'(0));

    // 4: unmapped address -> 4 DECERR beats with RREADY toggling.
    ARVALID = 1'b1;
    ARADDR  = 32'h0005_0000;
    ARLEN   = 4'd3;
    ARID    = 8'h2A;
    #2;
    chk("t4_arvalid_s", 64'(ARVALID_S), 64'(0));
    chk("t4_arready", 64'(ARREADY), 64'(1));
    for (int i = 0; i < 4; i++) begin
      sb.push_back(beat_t'{id: 8'h2A, data: 32'h0, resp: 2'b11, last: (i == 3)});
    end
    tick();
    ARVALID = 1'b0;
    acc = 0;
    rdy = 1'b1;
    for (int c = 0; c < 20 && acc < 4; c++) begin
      RREADY = rdy;
      #2;
      if (c == 0) chk("t4_first_beat_valid", 64'(RVALID), 64'(1));
      if (RVALID && RREADY) begin
        expect_beat("t4_def_r");
        acc++;
      end
      tick();
      rdy = !rdy;
    end
    RREADY = 1'b1;
    #2;
    chk("t4_beats_accepted", 64'(acc), 64'(4));
    chk("t4_rvalid_after", 64'(RVALID), 64'(0));
    chk("t4_cnt_end", 64'(dut.cnt_q), 64'(0));

    // 5: slave1 beat pending while slave0 is the target stays stalled.
    ARVALID = 1'b1;
    ARADDR  = 32'h0000_0020;
    ARLEN   = 4'd0;
    ARID    = 8'h05;
    tick();
    ARVALID     = 1'b0;
    RVALID_S[1] = 1'b1;
    RID_S[15:8] = 8'h77;
    RDATA_S[63:32] = 32'hDEAD_BEEF;
    RLAST_S[1]  = 1'b1;
    #2;
    chk("t5_rvalid_blocked", 64'(RVALID), 64'(0));
    chk("t5_rready_s_pre", 64'(RREADY_S), 64'(2'b01));
    slave_beat(0, 8'h05, 32'h0000_0055, 1'b1);
    #2;
    chk("t5_rvalid_idle", 64'(RVALID), 64'(0));
    chk("t5_rready_s_idle", 64'(RREADY_S), 64'(0));
    RVALID_S[1] = 1'b0;
    RLAST_S[1]  = 1'b0;

    // 6: reset in the middle of a DECERR burst discards it.
    ARVALID = 1'b1;
    ARADDR  = 32'h0007_0000;
    ARLEN   = 4'd3;
    ARID    = 8'h33;
    #2;
    chk("t6_arvalid_s", 64'(ARVALID_S), 64'(0));
    for (int i = 0; i < 4; i++) begin
      sb.push_back(beat_t'{id: 8'h33, data: 32'h0, resp: 2'b11, last: (i == 3)});
    end
    tick();
    ARVALID = 1'b0;
    #2;
    expect_beat("t6_def_r");
    tick();
    #2;
    chk("t6_second_beat_valid", 64'(RVALID), 64'(1));
    ARESET = 1'b1;
    #1;
    chk("t6_rst_rvalid", 64'(RVALID), 64'(0));
    chk("t6_rst_rlast", 64'(RLAST), 64'(0));
    chk("t6_rst_rresp", 64'(RRESP), 64'(0));
    chk("t6_rst_rid", 64'(RID), 64'(0));
    chk("t6_rst_arready", 64'(ARREADY), 64'(0));
    sb.delete();
    tick();
    ARESET = 1'b0;
    chk("t6_cnt_after_rst", 64'(dut.cnt_q), 64'(0));
    ARVALID = 1'b1;
    ARADDR  = 32'h0000_0030;
    ARLEN   = 4'd0;
    ARID    = 8'h09;
    #2;
    chk("t6_arready", 64'(ARREADY), 64'(1));
    chk("t6_arvalid_s0", 64'(ARVALID_S), 64'(2'b01));
    tick();
    ARVALID = 1'b0;
    chk("t6_cnt_one", 64'(dut.cnt_q), 64'(1));
    slave_beat(0, 8'h09, 32'h0000_0099, 1'b1);
    chk("t6_cnt_end", 64'(dut.cnt_q), 64'(0));
    chk("sb_drained", 64'(sb.size()), 64'(0));

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
